// File: rtl/eth_link_failover_ctrl.sv
// Selects between the 10GBASE-R and 1000BASE-T interfaces in the IP-stack clock domain.
// Debounces both link flags, gives 10G precedence, and switches only at frame boundaries.
module eth_link_failover_ctrl #(
  parameter int unsigned UP_DEBOUNCE   = 1562500,
  parameter int unsigned DOWN_FILTER   = 16,
  parameter int unsigned DRAIN_TIMEOUT = 65536,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   baser_link_up,
  input  logic                   baset_link_up,
  input  logic                   rx_frame_active,
  input  logic                   tx_frame_active,
  output logic [1:0]             rx_sel,
  output logic [1:0]             tx_sel,
  output logic                   tx_start_allow,
  output logic                   active_link_up,
  output logic                   link_change,
  output logic [COUNT_WIDTH-1:0] switch_count
);

  localparam int unsigned FILT_MAX = (UP_DEBOUNCE > DOWN_FILTER) ? UP_DEBOUNCE : DOWN_FILTER;
  localparam int unsigned FW       = $clog2(FILT_MAX) + 1;
  localparam int unsigned DW       = $clog2(DRAIN_TIMEOUT) + 1;

  localparam logic [FW-1:0] UP_LAST    = FW'(UP_DEBOUNCE - 1);
  localparam logic [FW-1:0] DOWN_LAST  = FW'(DOWN_FILTER - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {NONE, BASET, BASER, DRAIN} state_t;

  // Index 1 is the 10G link, index 0 the 1G link.
  logic [1:0]    link_in;
  logic [1:0]    ok;
  logic [FW-1:0] fcnt [2];

  assign link_in = {baser_link_up, baset_link_up};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ok      <= '0;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (link_in[i] == ok[i]) begin
          fcnt[i] <= '0;
        end else if (link_in[i] ? (fcnt[i] == UP_LAST) : (fcnt[i] == DOWN_LAST)) begin
          ok[i]   <= link_in[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  logic baser_ok, baset_ok;
  assign baser_ok = ok[1];
  assign baset_ok = ok[0];

  function automatic logic [1:0] enc(state_t s);
    case (s)
      BASET:   return 2'b01;
      BASER:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic link_ok(state_t s, logic r_ok, logic t_ok);
    case (s)
      BASER:   return r_ok;
      BASET:   return t_ok;
      default: return 1'b0;
    endcase
  endfunction

  state_t        state, state_nxt;
  state_t        target, target_nxt;
  state_t        old, old_nxt;
  logic [DW-1:0] drain_cnt;
  logic          tgt_ok, old_ok;
  state_t        stable_cur, stable_nxt;
  logic          chg;

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    old_nxt    = old;
    tgt_ok     = link_ok(target, baser_ok, baset_ok);
    old_ok     = link_ok(old, baser_ok, baset_ok);
    unique case (state)
      NONE: begin
        if (baser_ok)      state_nxt = BASER;
        else if (baset_ok) state_nxt = BASET;
      end
      BASET: begin
        if (!baset_ok) begin
          if (baser_ok) state_nxt = BASER;
          else          state_nxt = NONE;
        end else if (baser_ok) begin
          state_nxt  = DRAIN;
          old_nxt    = BASET;
          target_nxt = BASER;
        end
      end
      BASER: begin
        if (!baser_ok) begin
          if (baset_ok) state_nxt = BASET;
          else          state_nxt = NONE;
        end
      end
      DRAIN: begin
        // Link loss aborts take priority over the normal drain exit.
        if (!tgt_ok && !old_ok)                                         state_nxt = NONE;
        else if (!tgt_ok)                                               state_nxt = old;
        else if (!old_ok)                                               state_nxt = target;
        else if ((!rx_frame_active && !tx_frame_active) || drain_cnt == DRAIN_LAST) state_nxt = target;
      end
      default: state_nxt = NONE;
    endcase
  end

  // DRAIN is transparent for change reporting: it still counts as the old link.
  always_comb begin
    stable_cur = (state == DRAIN) ? old : state;
    stable_nxt = (state_nxt == DRAIN) ? old_nxt : state_nxt;
    chg        = (state_nxt != DRAIN) && (state_nxt != stable_cur);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= NONE;
      target         <= NONE;
      old            <= NONE;
      drain_cnt      <= '0;
      rx_sel         <= '0;
      tx_sel         <= '0;
      tx_start_allow <= 1'b0;
      active_link_up <= 1'b0;
      link_change    <= 1'b0;
      switch_count   <= '0;
    end else begin
      state          <= state_nxt;
      target         <= target_nxt;
      old            <= old_nxt;
      drain_cnt      <= (state == DRAIN && state_nxt == DRAIN) ? drain_cnt + DW'(1) : '0;
      rx_sel         <= enc(stable_nxt);
      tx_sel         <= enc(stable_nxt);
      tx_start_allow <= (state_nxt == BASET) || (state_nxt == BASER);
      active_link_up <= (state_nxt != NONE);
      link_change    <= chg;
      if (chg && switch_count != '1) switch_count <= switch_count + COUNT_WIDTH'(1);
    end
  end

endmodule
